// File: rtl/gate_truth_sweeper.sv
// Clocked truth-table sweeper: drives every input vector into a small gate,
// samples its output after a hold period and reports mismatches.
module gate_truth_sweeper #(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 5,
  parameter int FUNC        = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_fail_seen;
  logic            w_accept;
  logic            w_sample;
  logic            w_mis;
  logic            w_last;

  function automatic logic expected_out(input logic [N_IN-1:0] v);
    case (FUNC)
      0:       return &v;
      1:       return |v;
      2:       return ^v;
      default: return ~&v;
    endcase
  endfunction

  always_comb begin
    w_accept    = start && (r_state != DRIVE);
    w_sample    = (r_state == DRIVE) && (r_hold_cnt == HOLD_LAST);
    w_mis       = w_sample && (dut_y != expected_out(stim));
    w_last      = &stim;
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = DRIVE;
      DRIVE:   if (w_sample && w_last) w_state_nxt = DONE;
      DONE:    if (w_accept) w_state_nxt = DRIVE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_vec    <= '0;
      r_hold_cnt  <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_accept) begin
      stim        <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_vec    <= '0;
      r_hold_cnt  <= '0;
      r_fail_seen <= 1'b0;
    end else if (r_state == DRIVE) begin
      if (!w_sample) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end else begin
        if (w_mis) begin
          err_count <= err_count + (N_IN+1)'(1);
          if (!r_fail_seen) begin
            fail_vec    <= stim;
            r_fail_seen <= 1'b1;
          end
        end
        r_hold_cnt <= '0;
        if (!w_last) begin
          stim <= stim + N_IN'(1);
        end else begin
          // Verdict must include a mismatch found on this final sample edge.
          stim <= '0;
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == '0) && !w_mis;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Bench for gate_truth_sweeper: three configurations driven by truth-table
// gate models, checked against an arithmetic reference of the gate functions.
module tb_gate_truth_sweeper;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_a [3];
  logic [255:0] tt_a [3];

  logic [1:0] s0;  logic [2:0] s1;  logic [0:0] s2;
  logic [2:0] e0;  logic [3:0] e1;  logic [1:0] e2;
  logic [1:0] f0;  logic [2:0] f1;  logic [0:0] f2;
  logic b0, b1, b2, d0, d1, d2, p0, p1, p2, y0, y1, y2;

  logic [7:0] stim_a [3];
  logic [7:0] fv_a   [3];
  logic [8:0] err_a  [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       pass_a [3];

  int n_tests = 0;
  int n_fails = 0;

  always #5 clk = ~clk;

  assign y0 = tt_a[0][s0];
  assign y1 = tt_a[1][s1];
  assign y2 = tt_a[2][s2];

  gate_truth_sweeper #(.N_IN(2), .HOLD_CYCLES(5), .FUNC(0)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .dut_y(y0), .stim(s0),
    .busy(b0), .done(d0), .pass(p0), .err_count(e0), .fail_vec(f0));
  gate_truth_sweeper #(.N_IN(3), .HOLD_CYCLES(2), .FUNC(2)) u_xor (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .dut_y(y1), .stim(s1),
    .busy(b1), .done(d1), .pass(p1), .err_count(e1), .fail_vec(f1));
  gate_truth_sweeper #(.N_IN(1), .HOLD_CYCLES(1), .FUNC(3)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .dut_y(y2), .stim(s2),
    .busy(b2), .done(d2), .pass(p2), .err_count(e2), .fail_vec(f2));

  always_comb begin
    stim_a[0] = 8'(s0); stim_a[1] = 8'(s1); stim_a[2] = 8'(s2);
    fv_a[0]   = 8'(f0); fv_a[1]   = 8'(f1); fv_a[2]   = 8'(f2);
    err_a[0]  = 9'(e0); err_a[1]  = 9'(e1); err_a[2]  = 9'(e2);
    busy_a[0] = b0; busy_a[1] = b1; busy_a[2] = b2;
    done_a[0] = d0; done_a[1] = d1; done_a[2] = d2;
    pass_a[0] = p0; pass_a[1] = p1; pass_a[2] = p2;
  end

  function automatic int cfg_n(input int id);
    return (id == 0) ? 2 : (id == 1) ? 3 : 1;
  endfunction
  function automatic int cfg_h(input int id);
    return (id == 0) ? 5 : (id == 1) ? 2 : 1;
  endfunction
  function automatic int cfg_f(input int id);
    return (id == 0) ? 0 : (id == 1) ? 2 : 3;
  endfunction

  // Gate functions expressed through the number of ones in the vector.
  function automatic bit ref_gate(input int func, input int n, input int v);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (func)
      0:       return ones == n;
      1:       return ones > 0;
      2:       return (ones % 2) == 1;
      default: return ones != n;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int id = 0; id < 3; id++)
      chk($sformatf("%s_u%0d", tag, id),
          {busy_a[id], done_a[id], pass_a[id], err_a[id], stim_a[id], fv_a[id]}, 64'd0);
  endtask

  // mode 0: plain sweep; 1: extra start at edge k+7; 2: extra start on the done edge
  task automatic run_sweep(input int id, input int mode, input string tag);
    int n, h, nv, nh, exp_err, exp_fail, run_err;
    bit mis [256];
    n = cfg_n(id); h = cfg_h(id); nv = 1 << n; nh = nv * h;
    exp_err = 0; exp_fail = 0;
    for (int v = 0; v < nv; v++) begin
      mis[v] = (tt_a[id][v] != ref_gate(cfg_f(id), n, v));
      if (mis[v]) begin
        if (exp_err == 0) exp_fail = v;
        exp_err++;
      end
    end
    @(negedge clk) start_a[id] = 1'b1;
    @(negedge clk) start_a[id] = 1'b0;
    for (int c = 0; c < nh; c++) begin
      run_err = 0;
      for (int j = 0; (j + 1) * h <= c; j++) run_err += int'(mis[j]);
      chk($sformatf("%s_cyc%0d", tag, c),
          {busy_a[id], done_a[id], err_a[id], stim_a[id]},
          {1'b1, 1'b0, 9'(run_err), 8'(c / h)});
      start_a[id] = (mode == 1 && c == 6) || (mode == 2 && c == nh - 1);
      @(negedge clk);
    end
    start_a[id] = 1'b0;
    chk({tag, "_end_state"}, {busy_a[id], done_a[id], stim_a[id]}, {1'b0, 1'b1, 8'd0});
    chk({tag, "_err_count"}, err_a[id], exp_err);
    chk({tag, "_fail_vec"}, fv_a[id], exp_fail);
    chk({tag, "_pass"}, pass_a[id], exp_err == 0);
    if (mode == 2) begin
      @(negedge clk);
      chk({tag, "_done_edge_start"}, {busy_a[id], done_a[id], err_a[id]},
          {1'b0, 1'b1, 9'(exp_err)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    tt_a[0] = 256'h8;
    tt_a[1] = 256'h96;
    tt_a[2] = 256'h1;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    run_sweep(0, 1, "and_ok_repulse");
    run_sweep(0, 0, "and_ok_again");
    tt_a[0] = 256'h0;
    run_sweep(0, 0, "and_stuck0");
    tt_a[0] = 256'hF;
    run_sweep(0, 0, "and_stuck1");
    run_sweep(1, 0, "xor_ok");
    tt_a[1] = 256'h69;
    run_sweep(1, 0, "xnor_model");
    run_sweep(2, 2, "nand_ok");
    tt_a[2] = 256'h0;
    run_sweep(2, 0, "nand_stuck0");

    // Asynchronous reset in the middle of a sweep, between clock edges.
    tt_a[0] = 256'hF;
    @(negedge clk) start_a[0] = 1'b1;
    @(negedge clk) start_a[0] = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    chk_reset("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("after_rst_idle");

    for (int r = 0; r < 8; r++) begin
      int id;
      id = $urandom_range(0, 2);
      tt_a[id] = {8{$urandom}};
      run_sweep(id, (id == 2) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 2),
                $sformatf("rand%0d_u%0d", r, id));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
